// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: queued write requests and the
// live-tagged queue entry that lets an ALU write squash a stale load.
package wb_pkg;

   localparam int         XLEN   = 32;
   localparam logic [4:0] REG_X0 = 5'd0;

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] wd;
   } wb_req_t;

   typedef struct packed {
      logic    live;
      wb_req_t req;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular LSU result queue with per-entry squash-by-rd and a one-hot OR of
// the destinations still live in the queue.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  wb_req_t                push_req,
   input  logic                   pop,
   input  logic                   squash,
   input  logic [4:0]             squash_rd,
   output wb_entry_t              head,
   output logic [$clog2(DEPTH):0] count,
   output logic [31:0]            liveMask
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   wb_entry_t     mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW:0]   count_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign push_ok_s = push && (count_r != FULL);
   assign pop_ok_s  = pop && (count_r != {(PW+1){1'b0}});

   // Popped slots drop their live bit so stale data never reaches liveMask.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i].live    <= 1'b0;
            mem_r[i].req.rd  <= 5'd0;
            mem_r[i].req.wd  <= {XLEN{1'b0}};
         end
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {(PW+1){1'b0}};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (squash && mem_r[i].live && (mem_r[i].req.rd == squash_rd)) begin
               mem_r[i].live <= 1'b0;
            end else begin
               mem_r[i].live <= mem_r[i].live;
            end
         end
         if (pop_ok_s) begin
            mem_r[rd_ptr_r].live <= 1'b0;
            rd_ptr_r             <= rd_ptr_r + PW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         if (push_ok_s) begin
            mem_r[wr_ptr_r].live <= 1'b1;
            mem_r[wr_ptr_r].req  <= push_req;
            wr_ptr_r             <= wr_ptr_r + PW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (PW+1)'(1);
            2'b01:   count_r <= count_r - (PW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   always_comb begin
      liveMask = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         liveMask = liveMask | ({31'd0, mem_r[i].live} << mem_r[i].req.rd);
      end
      liveMask[0] = 1'b0;
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU > queue head > direct LSU, one registered write per
// cycle. Define WB_BYPASS_EN to enable the direct LSU path.
module wb_arbiter #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   aluValid,
   input  logic [4:0]             aluRd,
   input  logic [XLEN-1:0]        aluWd,
   input  logic                   lsuValid,
   output logic                   lsuReady,
   input  logic [4:0]             lsuRd,
   input  logic [XLEN-1:0]        lsuWd,
   output logic                   regWrite,
   output logic [4:0]             rd,
   output logic [XLEN-1:0]        wd,
   output logic [31:0]            pendingMask,
   output logic [$clog2(DEPTH):0] fifoCount
);

   import wb_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic          alu_wr_s;
   logic          lsu_fire_s;
   logic          lsu_keep_s;
   logic          fifo_empty_s;
   logic          pop_s;
   logic          push_s;
   logic          direct_s;
   wb_req_t       push_req_s;
   wb_entry_t     head_s;
   logic [CW-1:0] count_s;
   logic [31:0]   live_mask_s;

   assign lsuReady = (count_s != FULL);

   // An LSU result colliding with a same-cycle ALU write to the same rd is
   // older, so it is accepted and thrown away rather than queued.
   always_comb begin
      alu_wr_s     = aluValid && (aluRd != REG_X0);
      lsu_fire_s   = lsuValid && lsuReady;
      lsu_keep_s   = lsu_fire_s && (lsuRd != REG_X0) && !(alu_wr_s && (lsuRd == aluRd));
      fifo_empty_s = (count_s == {CW{1'b0}});
      pop_s        = !alu_wr_s && !fifo_empty_s;
`ifdef WB_BYPASS_EN
      direct_s     = lsu_keep_s && !alu_wr_s && fifo_empty_s;
`else
      direct_s     = 1'b0;
`endif
      push_s        = lsu_keep_s && !direct_s;
      push_req_s.rd = lsuRd;
      push_req_s.wd = lsuWd;
   end

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .push_req  (push_req_s),
      .pop       (pop_s),
      .squash    (alu_wr_s),
      .squash_rd (aluRd),
      .head      (head_s),
      .count     (count_s),
      .liveMask  (live_mask_s)
   );

   // A squashed head is still popped but produces a dead write cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regWrite <= 1'b0;
         rd       <= 5'd0;
         wd       <= {XLEN{1'b0}};
      end else if (alu_wr_s) begin
         regWrite <= 1'b1;
         rd       <= aluRd;
         wd       <= aluWd;
      end else if (pop_s && head_s.live) begin
         regWrite <= 1'b1;
         rd       <= head_s.req.rd;
         wd       <= head_s.req.wd;
      end else if (direct_s) begin
         regWrite <= 1'b1;
         rd       <= lsuRd;
         wd       <= lsuWd;
      end else begin
         regWrite <= 1'b0;
      end
   end

   assign pendingMask = live_mask_s;
   assign fifoCount   = count_s;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table-driven bench for wb_arbiter plus hand-written sequences for
// the direct path (WB_BYPASS_EN aware) and reset with queued entries.
module tb_wb_arbiter;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        aluValid = 1'b0;
   logic [4:0]  aluRd = 5'd0;
   logic [31:0] aluWd = 32'd0;
   logic        lsuValid = 1'b0;
   logic [4:0]  lsuRd = 5'd0;
   logic [31:0] lsuWd = 32'd0;
   logic        lsuReady;
   logic        regWrite;
   logic [4:0]  rd;
   logic [31:0] wd;
   logic [31:0] pendingMask;
   logic [2:0]  fifoCount;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] rf [32] = '{default: 32'd0};

   always #5 clk = ~clk;

   wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .aluValid(aluValid), .aluRd(aluRd), .aluWd(aluWd),
      .lsuValid(lsuValid), .lsuReady(lsuReady), .lsuRd(lsuRd), .lsuWd(lsuWd),
      .regWrite(regWrite), .rd(rd), .wd(wd),
      .pendingMask(pendingMask), .fifoCount(fifoCount)
   );

   always_ff @(posedge clk) begin
      if (regWrite) rf[rd] <= wd;
   end

   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [31:0] awd;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] lwd;
      logic        we;
      logic [4:0]  erd;
      logic [31:0] ewd;
      logic        rdy;
      logic [2:0]  cnt;
      logic [31:0] pm;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic av, input int ard, input int awd,
                               input logic lv, input int lrd, input int lwd,
                               input logic we, input int erd, input int ewd,
                               input logic rdy, input int cnt, input logic [31:0] pm);
      vec_t v;
      v.av = av;  v.ard = 5'(ard); v.awd = 32'(awd);
      v.lv = lv;  v.lrd = 5'(lrd); v.lwd = 32'(lwd);
      v.we = we;  v.erd = 5'(erd); v.ewd = 32'(ewd);
      v.rdy = rdy; v.cnt = 3'(cnt); v.pm = pm;
      return v;
   endfunction

   function automatic logic [31:0] b(input int n);
      return 32'd1 << n;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic av, input int ard, input int awd,
                        input logic lv, input int lrd, input int lwd);
      aluValid = av; aluRd = 5'(ard); aluWd = 32'(awd);
      lsuValid = lv; lsuRd = 5'(lrd); lsuWd = 32'(lwd);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = mk(1'b1, 5, 42,   1'b0, 0, 0,     1'b1, 5, 42,    1'b1, 0, 32'd0);
      vecs[1]  = mk(1'b1, 0, 99,   1'b1, 0, 77,    1'b0, 0, 0,     1'b1, 0, 32'd0);
      vecs[2]  = mk(1'b0, 0, 0,    1'b0, 0, 0,     1'b0, 0, 0,     1'b1, 0, 32'd0);
      vecs[3]  = mk(1'b1, 8, 3,    1'b1, 8, 4,     1'b1, 8, 3,     1'b1, 0, 32'd0);
      vecs[4]  = mk(1'b0, 0, 0,    1'b0, 0, 0,     1'b0, 0, 0,     1'b1, 0, 32'd0);
      vecs[5]  = mk(1'b0, 0, 0,    1'b0, 0, 0,     1'b0, 0, 0,     1'b1, 0, 32'd0);
      vecs[6]  = mk(1'b1, 20, 200, 1'b1, 10, 100,  1'b1, 20, 200,  1'b1, 1, b(10));
      vecs[7]  = mk(1'b1, 21, 201, 1'b1, 11, 101,  1'b1, 21, 201,  1'b1, 2, b(10)|b(11));
      vecs[8]  = mk(1'b1, 22, 202, 1'b1, 12, 102,  1'b1, 22, 202,  1'b1, 3, b(10)|b(11)|b(12));
      vecs[9]  = mk(1'b1, 23, 203, 1'b1, 13, 103,  1'b1, 23, 203,  1'b0, 4, b(10)|b(11)|b(12)|b(13));
      vecs[10] = mk(1'b1, 24, 204, 1'b1, 14, 104,  1'b1, 24, 204,  1'b0, 4, b(10)|b(11)|b(12)|b(13));
      vecs[11] = mk(1'b1, 25, 205, 1'b1, 14, 104,  1'b1, 25, 205,  1'b0, 4, b(10)|b(11)|b(12)|b(13));
      vecs[12] = mk(1'b0, 0, 0,    1'b1, 14, 104,  1'b1, 10, 100,  1'b1, 3, b(11)|b(12)|b(13));
      vecs[13] = mk(1'b0, 0, 0,    1'b1, 14, 104,  1'b1, 11, 101,  1'b1, 3, b(12)|b(13)|b(14));
      vecs[14] = mk(1'b0, 0, 0,    1'b0, 0, 0,     1'b1, 12, 102,  1'b1, 2, b(13)|b(14));
      vecs[15] = mk(1'b0, 0, 0,    1'b0, 0, 0,     1'b1, 13, 103,  1'b1, 1, b(14));
      vecs[16] = mk(1'b0, 0, 0,    1'b0, 0, 0,     1'b1, 14, 104,  1'b1, 0, 32'd0);
      vecs[17] = mk(1'b0, 0, 0,    1'b0, 0, 0,     1'b0, 0, 0,     1'b1, 0, 32'd0);
      vecs[18] = mk(1'b1, 9, 50,   1'b1, 7, 1,     1'b1, 9, 50,    1'b1, 1, b(7));
      vecs[19] = mk(1'b1, 7, 2,    1'b0, 0, 0,     1'b1, 7, 2,     1'b1, 1, 32'd0);
      vecs[20] = mk(1'b0, 0, 0,    1'b0, 0, 0,     1'b0, 0, 0,     1'b1, 0, 32'd0);
      vecs[21] = mk(1'b0, 0, 0,    1'b0, 0, 0,     1'b0, 0, 0,     1'b1, 0, 32'd0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst.regWrite", {31'd0, regWrite}, 32'd0);
      check("rst.rd", {27'd0, rd}, 32'd0);
      check("rst.wd", wd, 32'd0);
      check("rst.pendingMask", pendingMask, 32'd0);
      check("rst.lsuReady", {31'd0, lsuReady}, 32'd1);
      check("rst.fifoCount", {29'd0, fifoCount}, 32'd0);
      step();

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].av, int'(vecs[i].ard), int'(vecs[i].awd),
               vecs[i].lv, int'(vecs[i].lrd), int'(vecs[i].lwd));
         step();
         check($sformatf("v%0d.regWrite", i), {31'd0, regWrite}, {31'd0, vecs[i].we});
         if (vecs[i].we) begin
            check($sformatf("v%0d.rd", i), {27'd0, rd}, {27'd0, vecs[i].erd});
            check($sformatf("v%0d.wd", i), wd, vecs[i].ewd);
         end
         check($sformatf("v%0d.lsuReady", i), {31'd0, lsuReady}, {31'd0, vecs[i].rdy});
         check($sformatf("v%0d.fifoCount", i), {29'd0, fifoCount}, {29'd0, vecs[i].cnt});
         check($sformatf("v%0d.pendingMask", i), pendingMask, vecs[i].pm);
      end

      check("rf.x5", rf[5], 32'd42);
      check("rf.x8", rf[8], 32'd3);
      check("rf.x7", rf[7], 32'd2);
      check("rf.x10", rf[10], 32'd100);
      check("rf.x14", rf[14], 32'd104);
      check("rf.x0", rf[0], 32'd0);

      // Empty queue, ALU idle: LSU latency depends on the direct path.
      drive(1'b0, 0, 0, 1'b1, 15, 150);
      step();
`ifdef WB_BYPASS_EN
      check("dir1.regWrite", {31'd0, regWrite}, 32'd1);
      check("dir1.rd", {27'd0, rd}, 32'd15);
      check("dir1.wd", wd, 32'd150);
      check("dir1.fifoCount", {29'd0, fifoCount}, 32'd0);
`else
      check("dir1.regWrite", {31'd0, regWrite}, 32'd0);
      check("dir1.fifoCount", {29'd0, fifoCount}, 32'd1);
      check("dir1.pendingMask", pendingMask, b(15));
`endif
      drive(1'b0, 0, 0, 1'b0, 0, 0);
      step();
`ifdef WB_BYPASS_EN
      check("dir2.regWrite", {31'd0, regWrite}, 32'd0);
`else
      check("dir2.regWrite", {31'd0, regWrite}, 32'd1);
      check("dir2.rd", {27'd0, rd}, 32'd15);
      check("dir2.wd", wd, 32'd150);
`endif
      check("dir2.fifoCount", {29'd0, fifoCount}, 32'd0);

      // Queue three loads behind a busy ALU, then reset mid-operation.
      drive(1'b1, 20, 1, 1'b1, 1, 11);
      step();
      drive(1'b1, 21, 2, 1'b1, 2, 12);
      step();
      drive(1'b1, 22, 3, 1'b1, 3, 13);
      step();
      check("prerst.fifoCount", {29'd0, fifoCount}, 32'd3);
      check("prerst.pendingMask", pendingMask, b(1)|b(2)|b(3));
      drive(1'b0, 0, 0, 1'b0, 0, 0);
      rst_n = 1'b0;
      #1;
      check("midrst.fifoCount", {29'd0, fifoCount}, 32'd0);
      check("midrst.regWrite", {31'd0, regWrite}, 32'd0);
      check("midrst.pendingMask", pendingMask, 32'd0);
      check("midrst.lsuReady", {31'd0, lsuReady}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("postrst%0d.regWrite", i), {31'd0, regWrite}, 32'd0);
         check($sformatf("postrst%0d.fifoCount", i), {29'd0, fifoCount}, 32'd0);
      end
      check("rf.x1", rf[1], 32'd0);
      check("rf.x2", rf[2], 32'd0);
      check("rf.x3", rf[3], 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
